// File: rtl/muldiv_seq_if.sv
// Request/completion bundle between the execute stage and the RV32M muldiv sequencer.
interface muldiv_seq_if;
    logic        md_req;
    logic [2:0]  md_func3;
    logic [31:0] md_op1;
    logic [31:0] md_op2;
    logic [4:0]  md_rd;
    logic        md_flush;
    logic        md_stall;
    logic        md_done;
    logic [31:0] md_result;
    logic        md_wr_reg;
    logic [4:0]  md_wr_regindex;

    modport master (
        output md_req, md_func3, md_op1, md_op2, md_rd, md_flush,
        input  md_stall, md_done, md_result, md_wr_reg, md_wr_regindex
    );

    modport slave (
        input  md_req, md_func3, md_op1, md_op2, md_rd, md_flush,
        output md_stall, md_done, md_result, md_wr_reg, md_wr_regindex
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shared 32-step shift-add / restoring-divide datapath.
// Optional MULDIV_FAST_MUL_EN: single-cycle 33x33 signed multiply for the MUL class.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave md
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [63:0] acc_r;
    logic [31:0] opb_r;      // multiplicand (mul) or divisor (div) magnitude
    logic [2:0]  func3_r;
    logic [4:0]  rd_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic        done_r;
    logic        wr_reg_r;
    logic [31:0] result_r;
    logic [4:0]  wr_idx_r;

    logic        accept_s;
    logic        is_div_s;
    logic        op1_signed_s;
    logic        op2_signed_s;
    logic        s1_s;
    logic        s2_s;
    logic [31:0] abs1_s;
    logic [31:0] abs2_s;
    logic        special_s;
    logic [31:0] special_val_s;
    logic        fast_s;
    logic [31:0] fast_val_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] div_rem_s;
    logic [31:0] div_diff_s;
    logic [63:0] div_next_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] fix_val_s;

    // Request decode: acceptance, operand signs/magnitudes and the short-circuit divide cases.
    always_comb begin
        accept_s     = ((state_r == IDLE) || (state_r == DONE)) && md.md_req && !md.md_flush;
        is_div_s     = md.md_func3[2];
        op1_signed_s = (md.md_func3 == 3'd1) || (md.md_func3 == 3'd2) ||
                       (md.md_func3 == 3'd4) || (md.md_func3 == 3'd6);
        op2_signed_s = (md.md_func3 == 3'd1) || (md.md_func3 == 3'd4) || (md.md_func3 == 3'd6);
        s1_s         = op1_signed_s & md.md_op1[31];
        s2_s         = op2_signed_s & md.md_op2[31];
        abs1_s       = s1_s ? (32'd0 - md.md_op1) : md.md_op1;
        abs2_s       = s2_s ? (32'd0 - md.md_op2) : md.md_op2;
        special_s     = 1'b0;
        special_val_s = 32'd0;
        if (is_div_s && (md.md_op2 == 32'd0)) begin
            special_s     = 1'b1;
            special_val_s = md.md_func3[1] ? md.md_op1 : 32'hFFFF_FFFF;
        end else if (is_div_s && !md.md_func3[0] &&
                     (md.md_op1 == 32'h8000_0000) && (md.md_op2 == 32'hFFFF_FFFF)) begin
            special_s     = 1'b1;
            special_val_s = md.md_func3[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            special_s     = 1'b0;
            special_val_s = 32'd0;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fast_a_s;
    logic signed [32:0] fast_b_s;
    logic signed [65:0] fast_p_s;

    // Single-cycle signed 33x33 product; the extra bit carries each operand's signedness.
    always_comb begin
        fast_a_s   = $signed({s1_s, md.md_op1});
        fast_b_s   = $signed({s2_s, md.md_op2});
        fast_p_s   = fast_a_s * fast_b_s;
        fast_s     = !is_div_s;
        fast_val_s = (md.md_func3 == 3'd0) ? fast_p_s[31:0] : fast_p_s[63:32];
    end
`else
    // No fast multiplier: every multiply takes the iterative path.
    always_comb begin
        fast_s     = 1'b0;
        fast_val_s = 32'd0;
    end
`endif

    // One iteration step of the shared datapath.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[63:32]} + {1'b0, opb_r};
        if (acc_r[0]) begin
            mul_next_s = {mul_sum_s, acc_r[31:1]};
        end else begin
            mul_next_s = {1'b0, acc_r[63:1]};
        end
        // Shifted partial remainder needs 33 bits before the compare.
        div_rem_s  = acc_r[63:31];
        div_diff_s = div_rem_s[31:0] - opb_r;
        if (div_rem_s >= {1'b0, opb_r}) begin
            div_next_s = {div_diff_s, acc_r[30:0], 1'b1};
        end else begin
            div_next_s = {acc_r[62:0], 1'b0};
        end
    end

    // Sign correction and result-half selection applied in FIXUP.
    always_comb begin
        prod_s = neg_q_r ? (64'd0 - acc_r) : acc_r;
        quot_s = neg_q_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
        rem_s  = neg_r_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
        if (func3_r[2]) begin
            fix_val_s = func3_r[1] ? rem_s : quot_s;
        end else begin
            fix_val_s = (func3_r == 3'd0) ? prod_s[31:0] : prod_s[63:32];
        end
    end

    // Sequencer FSM with registered write-back outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= 5'd0;
            acc_r    <= 64'd0;
            opb_r    <= 32'd0;
            func3_r  <= 3'd0;
            rd_r     <= 5'd0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            done_r   <= 1'b0;
            wr_reg_r <= 1'b0;
            result_r <= 32'd0;
            wr_idx_r <= 5'd0;
        end else begin
            done_r   <= 1'b0;
            wr_reg_r <= 1'b0;
            if (md.md_flush) begin
                state_r <= IDLE;
            end else begin
                case (state_r)
                    IDLE, DONE: begin
                        if (accept_s) begin
                            cnt_r   <= 5'd0;
                            func3_r <= md.md_func3;
                            rd_r    <= md.md_rd;
                            neg_q_r <= s1_s ^ s2_s;
                            neg_r_r <= s1_s;
                            if (special_s || fast_s) begin
                                state_r  <= DONE;
                                acc_r    <= 64'd0;
                                opb_r    <= 32'd0;
                                done_r   <= 1'b1;
                                wr_reg_r <= (md.md_rd != 5'd0);
                                wr_idx_r <= md.md_rd;
                                result_r <= special_s ? special_val_s : fast_val_s;
                            end else if (is_div_s) begin
                                state_r <= CALC;
                                acc_r   <= {32'd0, abs1_s};
                                opb_r   <= abs2_s;
                            end else begin
                                state_r <= CALC;
                                acc_r   <= {32'd0, abs2_s};
                                opb_r   <= abs1_s;
                            end
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    CALC: begin
                        acc_r <= func3_r[2] ? div_next_s : mul_next_s;
                        if (cnt_r == 5'd31) begin
                            state_r <= FIXUP;
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end
                    FIXUP: begin
                        state_r  <= DONE;
                        result_r <= fix_val_s;
                        done_r   <= 1'b1;
                        wr_reg_r <= (rd_r != 5'd0);
                        wr_idx_r <= rd_r;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign md.md_stall       = (((state_r == IDLE) || (state_r == DONE)) && md.md_req && !md.md_flush) ||
                               (state_r == CALC) || (state_r == FIXUP);
    assign md.md_done        = done_r;
    assign md.md_wr_reg      = wr_reg_r;
    assign md.md_result      = result_r;
    assign md.md_wr_regindex = wr_idx_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: latency, results, special cases, flush, back-to-back and reset.
module tb_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    muldiv_seq_if md_if ();

    muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one request at posedge+1 and waits for md_done; hold keeps md_req up for back-to-back.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit hold,
                         output int lat, output logic [31:0] res, output logic wr,
                         output logic [4:0] idx, output logic stall0, output logic stall_run,
                         output logic stall_end);
        md_if.md_req   = 1'b1;
        md_if.md_func3 = f3;
        md_if.md_op1   = a;
        md_if.md_op2   = b;
        md_if.md_rd    = rd;
        lat       = -1;
        res       = 32'hxxxx_xxxx;
        wr        = 1'bx;
        idx       = 5'bxxxxx;
        stall_run = 1'b1;
        stall_end = 1'bx;
        @(negedge clk);
        stall0 = md_if.md_stall;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (md_if.md_done === 1'b1) begin
                lat = k;
                res = md_if.md_result;
                wr  = md_if.md_wr_reg;
                idx = md_if.md_wr_regindex;
                if (!hold) begin
                    md_if.md_req = 1'b0;
                    @(negedge clk);
                    stall_end = md_if.md_stall;
                end
                break;
            end
            @(negedge clk);
            if (md_if.md_stall !== 1'b1) stall_run = 1'b0;
        end
        if (lat < 0) md_if.md_req = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++; if (md_if.md_result !== 32'd0) $display("FAIL rst_result: got %h want %h", md_if.md_result, 32'd0); else pass_cnt++;
        total_cnt++; if (md_if.md_done !== 1'b0) $display("FAIL rst_done: got %b want 0", md_if.md_done); else pass_cnt++;
        total_cnt++; if (md_if.md_wr_reg !== 1'b0) $display("FAIL rst_wr_reg: got %b want 0", md_if.md_wr_reg); else pass_cnt++;
        total_cnt++; if (md_if.md_wr_regindex !== 5'd0) $display("FAIL rst_idx: got %0d want 0", md_if.md_wr_regindex); else pass_cnt++;
        total_cnt++; if (md_if.md_stall !== 1'b0) $display("FAIL rst_stall_idle: got %b want 0", md_if.md_stall); else pass_cnt++;
        md_if.md_req = 1'b1;
        #1;
        total_cnt++; if (md_if.md_stall !== 1'b1) $display("FAIL rst_stall_req: got %b want 1", md_if.md_stall); else pass_cnt++;
        md_if.md_req = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        int lat; logic [31:0] res; logic wr; logic [4:0] idx; logic s0, sr, se;
        @(posedge clk); #1;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (lat !== MUL_LAT) $display("FAIL mul_lat: got %0d want %0d", lat, MUL_LAT); else pass_cnt++;
        total_cnt++; if (res !== 32'hFFFF_FFEB) $display("FAIL mul_result: got %h want %h", res, 32'hFFFF_FFEB); else pass_cnt++;
        total_cnt++; if (wr !== 1'b1) $display("FAIL mul_wr_reg: got %b want 1", wr); else pass_cnt++;
        total_cnt++; if (idx !== 5'd5) $display("FAIL mul_idx: got %0d want 5", idx); else pass_cnt++;
        total_cnt++; if ((s0 !== 1'b1) || (sr !== 1'b1)) $display("FAIL mul_stall_busy: got %b%b want 11", s0, sr); else pass_cnt++;
        total_cnt++; if (se !== 1'b0) $display("FAIL mul_stall_done: got %b want 0", se); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (md_if.md_done !== 1'b0) $display("FAIL mul_done_pulse: got %b want 0", md_if.md_done); else pass_cnt++;
        total_cnt++; if (md_if.md_result !== 32'hFFFF_FFEB) $display("FAIL mul_result_hold: got %h want %h", md_if.md_result, 32'hFFFF_FFEB); else pass_cnt++;
    endtask

    task automatic test_mulh();
        int lat; logic [31:0] res; logic wr; logic [4:0] idx; logic s0, sr, se;
        @(posedge clk); #1;
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'h4000_0000) $display("FAIL mulh_result: got %h want %h", res, 32'h4000_0000); else pass_cnt++;
        @(posedge clk); #1;
        issue(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'h4000_0000) $display("FAIL mulhu_result: got %h want %h", res, 32'h4000_0000); else pass_cnt++;
        @(posedge clk); #1;
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'hFFFF_FFFF) $display("FAIL mulhsu_result: got %h want %h", res, 32'hFFFF_FFFF); else pass_cnt++;
        total_cnt++; if (lat !== MUL_LAT) $display("FAIL mulhsu_lat: got %0d want %0d", lat, MUL_LAT); else pass_cnt++;
        @(posedge clk); #1;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'hFFFF_FFFE) $display("FAIL mulhu_max: got %h want %h", res, 32'hFFFF_FFFE); else pass_cnt++;
    endtask

    task automatic test_div();
        int lat; logic [31:0] res; logic wr; logic [4:0] idx; logic s0, sr, se;
        @(posedge clk); #1;
        issue(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd10, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'hFFFF_FFFA) $display("FAIL div_result: got %h want %h", res, 32'hFFFF_FFFA); else pass_cnt++;
        total_cnt++; if (lat !== DIV_LAT) $display("FAIL div_lat: got %0d want %0d", lat, DIV_LAT); else pass_cnt++;
        @(posedge clk); #1;
        issue(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd11, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'hFFFF_FFFE) $display("FAIL rem_result: got %h want %h", res, 32'hFFFF_FFFE); else pass_cnt++;
        total_cnt++; if (lat !== DIV_LAT) $display("FAIL rem_lat: got %0d want %0d", lat, DIV_LAT); else pass_cnt++;
        @(posedge clk); #1;
        issue(3'd6, 32'd20, 32'hFFFF_FFFD, 5'd11, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'd2) $display("FAIL rem_negdiv: got %h want %h", res, 32'd2); else pass_cnt++;
        @(posedge clk); #1;
        issue(3'd5, 32'hFFFF_FFFF, 32'd2, 5'd12, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'h7FFF_FFFF) $display("FAIL divu_result: got %h want %h", res, 32'h7FFF_FFFF); else pass_cnt++;
        total_cnt++; if (lat !== DIV_LAT) $display("FAIL divu_lat: got %0d want %0d", lat, DIV_LAT); else pass_cnt++;
    endtask

    task automatic test_flush();
        int lat; logic [31:0] res; logic wr; logic [4:0] idx; logic s0, sr, se;
        int seen;
        @(posedge clk); #1;
        md_if.md_req   = 1'b1;
        md_if.md_func3 = 3'd4;
        md_if.md_op1   = 32'd1000;
        md_if.md_op2   = 32'd7;
        md_if.md_rd    = 5'd3;
        repeat (10) begin @(posedge clk); #1; end
        md_if.md_flush = 1'b1;
        @(posedge clk); #1;
        md_if.md_flush = 1'b0;
        md_if.md_req   = 1'b0;
        @(negedge clk);
        total_cnt++; if (md_if.md_stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", md_if.md_stall); else pass_cnt++;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (md_if.md_done !== 1'b0) seen++;
        end
        total_cnt++; if (seen !== 0) $display("FAIL flush_no_done: got %0d done cycles want 0", seen); else pass_cnt++;
        total_cnt++; if (md_if.md_result !== 32'h7FFF_FFFF) $display("FAIL flush_result: got %h want %h", md_if.md_result, 32'h7FFF_FFFF); else pass_cnt++;
        total_cnt++; if (md_if.md_wr_regindex !== 5'd12) $display("FAIL flush_idx: got %0d want 12", md_if.md_wr_regindex); else pass_cnt++;
        @(posedge clk); #1;
        issue(3'd5, 32'd1000, 32'd7, 5'd0, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'd142) $display("FAIL rd0_result: got %h want %h", res, 32'd142); else pass_cnt++;
        total_cnt++; if (wr !== 1'b0) $display("FAIL rd0_wr_reg: got %b want 0", wr); else pass_cnt++;
        total_cnt++; if (lat !== DIV_LAT) $display("FAIL rd0_lat: got %0d want %0d", lat, DIV_LAT); else pass_cnt++;
    endtask

    task automatic test_special();
        int lat; logic [31:0] res; logic wr; logic [4:0] idx; logic s0, sr, se;
        @(posedge clk); #1;
        issue(3'd4, 32'h0000_1234, 32'd0, 5'd1, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'hFFFF_FFFF) $display("FAIL div0_result: got %h want %h", res, 32'hFFFF_FFFF); else pass_cnt++;
        total_cnt++; if (lat !== 1) $display("FAIL div0_lat: got %0d want 1", lat); else pass_cnt++;
        total_cnt++; if ((s0 !== 1'b1) || (se !== 1'b0)) $display("FAIL div0_stall: got %b%b want 10", s0, se); else pass_cnt++;
        @(posedge clk); #1;
        issue(3'd7, 32'h0000_1234, 32'd0, 5'd2, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'h0000_1234) $display("FAIL remu0_result: got %h want %h", res, 32'h0000_1234); else pass_cnt++;
        total_cnt++; if (lat !== 1) $display("FAIL remu0_lat: got %0d want 1", lat); else pass_cnt++;
        @(posedge clk); #1;
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'h8000_0000) $display("FAIL divovf_result: got %h want %h", res, 32'h8000_0000); else pass_cnt++;
        total_cnt++; if (lat !== 1) $display("FAIL divovf_lat: got %0d want 1", lat); else pass_cnt++;
        @(posedge clk); #1;
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'd0) $display("FAIL removf_result: got %h want %h", res, 32'd0); else pass_cnt++;
        total_cnt++; if ((lat !== 1) || (idx !== 5'd4)) $display("FAIL removf_lat_idx: got %0d/%0d want 1/4", lat, idx); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; logic wr; logic [4:0] idx; logic s0, sr, se;
        @(posedge clk); #1;
        issue(3'd5, 32'd100, 32'd7, 5'd4, 1'b1, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'd14) $display("FAIL b2b_first: got %h want %h", res, 32'd14); else pass_cnt++;
        issue(3'd0, 32'd6, 32'd7, 5'd9, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (s0 !== 1'b1) $display("FAIL b2b_stall_in_done: got %b want 1", s0); else pass_cnt++;
        total_cnt++; if (lat !== MUL_LAT) $display("FAIL b2b_lat: got %0d want %0d", lat, MUL_LAT); else pass_cnt++;
        total_cnt++; if (res !== 32'd42) $display("FAIL b2b_second: got %h want %h", res, 32'd42); else pass_cnt++;
        total_cnt++; if (idx !== 5'd9) $display("FAIL b2b_idx: got %0d want 9", idx); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res; logic wr; logic [4:0] idx; logic s0, sr, se;
        @(posedge clk); #1;
        md_if.md_req   = 1'b1;
        md_if.md_func3 = 3'd4;
        md_if.md_op1   = 32'hFFFF_FFEC;
        md_if.md_op2   = 32'd3;
        md_if.md_rd    = 5'd7;
        repeat (20) begin @(posedge clk); #1; end
        md_if.md_req = 1'b0;
        rst_n        = 1'b0;
        #1;
        total_cnt++; if (md_if.md_result !== 32'd0) $display("FAIL midrst_result: got %h want 0", md_if.md_result); else pass_cnt++;
        total_cnt++; if (md_if.md_wr_regindex !== 5'd0) $display("FAIL midrst_idx: got %0d want 0", md_if.md_wr_regindex); else pass_cnt++;
        total_cnt++; if (md_if.md_stall !== 1'b0) $display("FAIL midrst_stall: got %b want 0", md_if.md_stall); else pass_cnt++;
        total_cnt++; if ((md_if.md_done !== 1'b0) || (md_if.md_wr_reg !== 1'b0)) $display("FAIL midrst_done: got %b%b want 00", md_if.md_done, md_if.md_wr_reg); else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0, lat, res, wr, idx, s0, sr, se);
        total_cnt++; if (res !== 32'hFFFF_FFEB) $display("FAIL postrst_result: got %h want %h", res, 32'hFFFF_FFEB); else pass_cnt++;
        total_cnt++; if (lat !== MUL_LAT) $display("FAIL postrst_lat: got %0d want %0d", lat, MUL_LAT); else pass_cnt++;
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        rst_n          = 1'b0;
        md_if.md_req   = 1'b0;
        md_if.md_func3 = 3'd0;
        md_if.md_op1   = 32'd0;
        md_if.md_op2   = 32'd0;
        md_if.md_rd    = 5'd0;
        md_if.md_flush = 1'b0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_flush();
        test_special();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV32M multiply/divide sequencer in the execute stage. It accepts one MUL/DIV-class operation per request from the decode/execute pipeline registers (`MD_OP` set, func3 as ALU op, operand1/operand2). It runs a shared 32-step shift-add / restoring-divide datapath and stalls the pipeline until the result is ready. On completion it emits a one-cycle register write-back.

## Interface
- No parameters; widths fixed at XLEN=32.
- `clk` in 1: core clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `md_req` in 1: operation request; requester holds it and its operands stable while `md_stall`=1.
- `md_func3` in 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `md_op1` in 32: rs1 value (multiplicand/dividend).
- `md_op2` in 32: rs2 value (multiplier/divisor).
- `md_rd` in 5: destination register index.
- `md_flush` in 1: kill any in-flight operation (branch mispredict/exception).
- `md_stall` out 1: hold decode/execute pipeline registers.
- `md_done` out 1: one-cycle completion pulse.
- `md_result` out 32: result; valid while `md_done`=1 and held until the next completion.
- `md_wr_reg` out 1: `md_done` & (`md_rd` latched ≠ 0).
- `md_wr_regindex` out 5: latched `md_rd`.

## Operation
- **States:** IDLE, CALC, FIXUP, DONE.
- **IDLE / DONE**
  - `md_req`=1 & `md_flush`=0 → latch func3, rd, |op1|, |op2|, sign flags, clear 64-bit accumulator, counter=0.
  - Divide with `md_op2`=0, or DIV/REM with op1=0x80000000 and op2=0xFFFFFFFF → go to DONE directly (special case).
  - Otherwise go to CALC.
  - No request → IDLE.
- **CALC:** one step per cycle; counter 0..31; when counter=31 → FIXUP.
  - Multiply: if multiplier LSB set, add multiplicand to upper half; shift the 64-bit accumulator right by 1.
  - Divide: shift {remainder, quotient} left by 1; if remainder ≥ divisor, subtract it and set quotient LSB.
- **FIXUP:** apply sign correction, select the result half, register `md_result` → DONE.
  - MUL: low 32 bits. MULH/MULHSU/MULHU: high 32 bits.
  - Product negated (two's complement, 64-bit) when signs differ. MULH treats both operands as signed, MULHSU only op1, MULHU neither.
  - DIV: quotient negated if op1/op2 signs differ.
  - REM: remainder takes the sign of op1.
  - DIVU/REMU: unsigned, no correction.
- **DONE:** `md_done`=1 for exactly this cycle. It may accept a new request (back-to-back); otherwise → IDLE.
- **Special cases:**
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op1.
  - Signed overflow: DIV → 0x80000000; REM → 0.
- **`md_stall`** = (IDLE|DONE) & `md_req` & !`md_flush`, or state ∈ {CALC, FIXUP}.
- **Flush:** `md_flush`=1 in any state → IDLE at the next edge, no `md_done`. `md_result`/`md_wr_regindex` keep their old values. Flush beats a same-cycle `md_req`.
- **Reset:** state IDLE, counter 0, accumulator 0, `md_result` 0, `md_wr_regindex` 0, `md_done` 0, `md_wr_reg` 0. `md_stall` follows its equation, so it is 0 unless `md_req`=1.

## Timing
- Accept cycle = cycle 0.
- Normal op: CALC in cycles 1–32, FIXUP in cycle 33, `md_done` in cycle 34. `md_stall` is high in cycles 0–33 and low in cycle 34.
- Special case: `md_done` in cycle 1; `md_stall` high only in cycle 0.
- Back-to-back: a request presented during the DONE cycle is accepted in that cycle; its DONE follows 34 (or 1) cycles later.
- Reset asserted mid-operation: immediate return to reset values, asynchronous to `clk`.
- All outputs except `md_stall` are registered.

## Configuration
- **`MULDIV_FAST_MUL_EN` defined:** MUL/MULH/MULHSU/MULHU are computed with a single-cycle 33×33 signed combinational multiply in the accept cycle. Path is IDLE → DONE, with `md_done` in cycle 1. Divides are unchanged.
- **Not defined:** all multiplies use the 32-step CALC path (34-cycle latency). No hardware multiplier is inferred.

## Test plan
- **MUL:** op1=7, op2=0xFFFFFFFD (−3), rd=5 → `md_done` in cycle 34 (cycle 1 with `MULDIV_FAST_MUL_EN`); `md_result`=0xFFFFFFEB; `md_wr_reg`=1; `md_wr_regindex`=5.
- **MULH / MULHU:** 0x80000000 × 0x80000000 → MULH 0x40000000; MULHU 0x40000000. MULHSU with op1=0xFFFFFFFF, op2=0xFFFFFFFF → 0xFFFFFFFF.
- **DIV / REM / DIVU:** DIV −20/3 → 0xFFFFFFFA; REM −20/3 → 0xFFFFFFFE; DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF; each `md_done` in cycle 34.
- **Special cases:**
  - DIV x/0 with op1=0x1234 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234.
  - DIV 0x80000000/−1 → 0x80000000; REM of the same operands → 0.
  - Each has `md_done` in cycle 1.
- **Flush:** `md_flush` in cycle 10 of a DIV → no `md_done`, `md_stall` low from cycle 11, `md_result` unchanged. A request with rd=0 completes with `md_done`=1 and `md_wr_reg`=0.
- **Back-to-back and reset:** a second request held during DONE is accepted with no IDLE gap and its result is correct. `rst_n` pulsed low in cycle 20 → all outputs at reset values immediately, and a new request completes normally afterwards.
